// File: rtl/pe_array_ins_issue_pkg.sv
// Shared definitions for the PE array instruction issue stage.
package pe_array_ins_issue_pkg;

    localparam int DEF_PE_INS_WIDTH = 24;

    // The PE array treats an all-zero instruction word as a NOP.
    localparam logic [DEF_PE_INS_WIDTH-1:0] DEF_PE_NOP_INS = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } issue_state_t;

endpackage

// File: rtl/pe_array_ins_issue_fifo.sv
// Synchronous FIFO holding {predication, data selection, instruction} entries.
module pe_ins_fifo #(
    parameter  int WIDTH = 28,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy decides which entries are live, so stale data is never read.
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/pe_array_ins_issue.sv
// Issue stage: buffers CP instructions and drives one instruction or NOP to the PE array IF every cycle.
module pe_array_ins_issue
    import pe_array_ins_issue_pkg::*;
#(
    parameter  int INS_WIDTH  = DEF_PE_INS_WIDTH,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CNT_WIDTH  = 16,
    localparam int FCNT_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int ENTRY_W    = INS_WIDTH + 4
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iCP_Ins_Valid,
    output logic                 oCP_Ins_Ready,
    input  logic [INS_WIDTH-1:0] iCP_Instruction,
    input  logic [1:0]           iCP_Data_Selection,
    input  logic [1:0]           iCP_Predication,
    input  logic                 iStall,
    input  logic                 iFlush,
    output logic [INS_WIDTH-1:0] oIMEM_IF_Instruction,
    output logic [1:0]           oData_Selection,
    output logic [1:0]           oPredication,
    output logic                 oIssue_Valid,
    output logic [FCNT_W-1:0]    oFifo_Count,
    output logic [CNT_WIDTH-1:0] oIssue_Count
);

    issue_state_t         state_q, state_d;
    logic [INS_WIDTH-1:0] ins_q, ins_d;
    logic [1:0]           dsel_q, dsel_d;
    logic [1:0]           pred_q, pred_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] issue_cnt_q, issue_cnt_d;

    logic [ENTRY_W-1:0]   fifo_rdata;
    logic [FCNT_W-1:0]    fifo_count;
    logic [FCNT_W-1:0]    count_next;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 cp_ready;
    logic                 push;
    logic                 pop;

    // Ready comes from the registered count only; a same-cycle pop does not free a slot early.
    assign cp_ready = !fifo_full;
    assign push     = iCP_Ins_Valid && cp_ready && !iFlush;
    assign pop      = ((state_q == ST_ISSUE) || (state_q == ST_IDLE)) &&
                      !fifo_empty && !iStall && !iFlush;

    pe_ins_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iClk),
        .reset   (iReset),
        .push    (push),
        .pop     (pop),
        .clear   (iFlush),
        .wr_data ({iCP_Predication, iCP_Data_Selection, iCP_Instruction}),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Occupancy after this edge, used by the FSM to see entries arriving or draining.
    always_comb begin
        count_next = fifo_count;
        if (iFlush) count_next = '0;
        else        count_next = fifo_count + FCNT_W'(push) - FCNT_W'(pop);
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (iFlush) begin
            state_d = ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (iStall)               state_d = ST_HOLD;
                    else if (count_next != 0) state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (iStall)               state_d = ST_HOLD;
                    else if (count_next == 0) state_d = ST_IDLE;
                end
                ST_HOLD: begin
                    if (!iStall) state_d = (count_next != 0) ? ST_ISSUE : ST_IDLE;
                end
                ST_FLUSH: begin
                    state_d = (count_next != 0) ? ST_ISSUE : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output register contents: FIFO head on a pop, otherwise a NOP.
    always_comb begin
        ins_d       = INS_WIDTH'(DEF_PE_NOP_INS);
        dsel_d      = '0;
        pred_d      = '0;
        valid_d     = 1'b0;
        issue_cnt_d = issue_cnt_q;
        if (pop) begin
            ins_d       = fifo_rdata[INS_WIDTH-1:0];
            dsel_d      = fifo_rdata[INS_WIDTH+1:INS_WIDTH];
            pred_d      = fifo_rdata[INS_WIDTH+3:INS_WIDTH+2];
            valid_d     = 1'b1;
            issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State, output and issue counter registers.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            ins_q       <= '0;
            dsel_q      <= '0;
            pred_q      <= '0;
            valid_q     <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ins_q       <= ins_d;
            dsel_q      <= dsel_d;
            pred_q      <= pred_d;
            valid_q     <= valid_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign oCP_Ins_Ready        = cp_ready;
    assign oIMEM_IF_Instruction = ins_q;
    assign oData_Selection      = dsel_q;
    assign oPredication         = pred_q;
    assign oIssue_Valid         = valid_q;
    assign oFifo_Count          = fifo_count;
    assign oIssue_Count         = issue_cnt_q;

endmodule

// File: tb/tb_pe_array_ins_issue.sv
// Self-checking bench for pe_array_ins_issue against a queue-based reference model.
module tb_pe_array_ins_issue;

    localparam int DEPTH = 4;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iCP_Ins_Valid;
    logic        oCP_Ins_Ready;
    logic [23:0] iCP_Instruction;
    logic [1:0]  iCP_Data_Selection;
    logic [1:0]  iCP_Predication;
    logic        iStall;
    logic        iFlush;
    logic [23:0] oIMEM_IF_Instruction;
    logic [1:0]  oData_Selection;
    logic [1:0]  oPredication;
    logic        oIssue_Valid;
    logic [2:0]  oFifo_Count;
    logic [15:0] oIssue_Count;

    pe_array_ins_issue dut (
        .iClk                 (iClk),
        .iReset               (iReset),
        .iCP_Ins_Valid        (iCP_Ins_Valid),
        .oCP_Ins_Ready        (oCP_Ins_Ready),
        .iCP_Instruction      (iCP_Instruction),
        .iCP_Data_Selection   (iCP_Data_Selection),
        .iCP_Predication      (iCP_Predication),
        .iStall               (iStall),
        .iFlush               (iFlush),
        .oIMEM_IF_Instruction (oIMEM_IF_Instruction),
        .oData_Selection      (oData_Selection),
        .oPredication         (oPredication),
        .oIssue_Valid         (oIssue_Valid),
        .oFifo_Count          (oFifo_Count),
        .oIssue_Count         (oIssue_Count)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model: queue of {pred, dsel, ins}, plus what the outputs must show.
    logic [27:0] mq[$];
    logic [23:0] m_ins;
    logic [1:0]  m_dsel;
    logic [1:0]  m_pred;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic        m_no_pop;     // previous cycle stalled or flushed: this cycle cannot issue
    logic        m_after_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    task automatic compare_all();
        check("ready",       32'(oCP_Ins_Ready),        32'(mq.size() < DEPTH));
        check("fifo_count",  32'(oFifo_Count),          32'(mq.size()));
        check("ins",         32'(oIMEM_IF_Instruction), 32'(m_ins));
        check("dsel",        32'(oData_Selection),      32'(m_dsel));
        check("pred",        32'(oPredication),         32'(m_pred));
        check("issue_valid", 32'(oIssue_Valid),         32'(m_valid));
        check("issue_count", 32'(oIssue_Count),         32'(m_cnt));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, compare at the next falling edge.
    task automatic step(input logic v, input logic [23:0] ins, input logic [1:0] ds,
                        input logic [1:0] pr, input logic st, input logic fl, input logic rs);
        logic ready;
        logic pop;
        logic [27:0] head;
        iCP_Ins_Valid      = v;
        iCP_Instruction    = ins;
        iCP_Data_Selection = ds;
        iCP_Predication    = pr;
        iStall             = st;
        iFlush             = fl;
        iReset             = rs;
        if (rs) begin
            mq.delete();
            {m_ins, m_dsel, m_pred, m_valid, m_cnt} = '0;
            m_no_pop      = 1'b0;
            m_after_flush = 1'b0;
        end else begin
            ready = (mq.size() < DEPTH);
            pop   = !m_no_pop && !st && !fl && (mq.size() > 0);
            {m_ins, m_dsel, m_pred, m_valid} = '0;
            if (pop) begin
                head    = mq.pop_front();
                m_pred  = head[27:26];
                m_dsel  = head[25:24];
                m_ins   = head[23:0];
                m_valid = 1'b1;
                m_cnt   = m_cnt + 16'd1;
            end
            if (fl)              mq.delete();
            else if (v && ready) mq.push_back({pr, ds, ins});
            m_no_pop      = fl || (st && !m_after_flush);
            m_after_flush = fl;
        end
        @(negedge iClk);
        cycle++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        check("lit_reset_ready", 32'(oCP_Ins_Ready), 32'd1);
        check("lit_reset_valid", 32'(oIssue_Valid),  32'd0);

        // Single instruction: NOP right after the push, instruction on the following cycle.
        idle(1);
        step(1'b1, 24'h123456, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        check("lit_single_nop", 32'(oIssue_Valid), 32'd0);
        idle(1);
        check("lit_single_ins",  32'(oIMEM_IF_Instruction), 32'h123456);
        check("lit_single_dsel", 32'(oData_Selection),      32'd2);
        check("lit_single_pred", 32'(oPredication),         32'd1);
        check("lit_single_cnt",  32'(oIssue_Count),         32'd1);
        idle(1);
        check("lit_single_after", 32'(oIssue_Valid), 32'd0);

        // Six back-to-back pushes.
        for (int i = 0; i < 6; i++) step(1'b1, 24'(24'hA0 + i), 2'(i), 2'(i + 1), 1'b0, 1'b0, 1'b0);
        idle(4);
        check("lit_b2b_cnt", 32'(oIssue_Count), 32'd7);

        // Stall: fill A,B,C while stalled, hold three more cycles, then release.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 24'(24'hA + i), 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("lit_stall_count", 32'(oFifo_Count),  32'd3);
        check("lit_stall_valid", 32'(oIssue_Valid), 32'd0);
        idle(5);

        // Flush with a simultaneous push of D, then push E.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 24'(24'hA + i), 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 24'hD, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0);
        check("lit_flush_count", 32'(oFifo_Count),  32'd0);
        check("lit_flush_valid", 32'(oIssue_Valid), 32'd0);
        step(1'b1, 24'hE, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("lit_flush_e", 32'(oIMEM_IF_Instruction), 32'hE);
        idle(2);

        // Reset mid-stream with two entries buffered.
        for (int i = 0; i < 2; i++) step(1'b1, 24'(24'h55 + i), 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("lit_rst_cnt",   32'(oIssue_Count), 32'd0);
        check("lit_rst_valid", 32'(oIssue_Valid), 32'd0);
        check("lit_rst_ins",   32'(oIMEM_IF_Instruction), 32'd0);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 9) < 7), 24'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 199) == 0));
        end

        // Counter wrap: 2^16 + 2 real issues from reset.
        do_reset();
        for (int i = 0; i < 65538; i++) step(1'b1, 24'(i), 2'(i), 2'(i >> 2), 1'b0, 1'b0, 1'b0);
        idle(3);
        check("lit_wrap_cnt", 32'(oIssue_Count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_array_ins_issue.md
Name: pe_array_ins_issue

Overview:
Issue stage that feeds the PE array instruction fetch inputs (instruction word, data selection, predication) from the control processor (CP) side. It buffers CP-issued PE instructions in a small FIFO and drives exactly one instruction or a NOP to the PE array every cycle. The PE array IF latches its inputs unconditionally each cycle, so this block inserts NOPs on stall, underflow and flush. It sits between the CP decode stage and the PE array IF stage.

Parameters:
INS_WIDTH, 24, PE instruction width; equals DEF_PE_INS_WIDTH.
FIFO_DEPTH, 4, buffered instructions; power of two, minimum 2.
CNT_WIDTH, 16, width of the issued-instruction counter.

Ports:
iClk  input  1  system clock, positive-edge trigger
iReset  input  1  global reset; synchronous, active-high
iCP_Ins_Valid  input  1  CP offers an instruction
oCP_Ins_Ready  output  1  block can accept an instruction
iCP_Instruction  input  INS_WIDTH  PE instruction word
iCP_Data_Selection  input  2  data selection bits for this instruction
iCP_Predication  input  2  predication bits for this instruction
iStall  input  1  PE array frozen; issue NOP, do not pop
iFlush  input  1  discard all buffered instructions
oIMEM_IF_Instruction  output  INS_WIDTH  to PE array IF instruction input
oData_Selection  output  2  to PE array IF data selection input
oPredication  output  2  to PE array IF predication input
oIssue_Valid  output  1  current output is a real instruction, not an inserted NOP
oFifo_Count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy
oIssue_Count  output  CNT_WIDTH  number of real instructions issued

Behaviour:
- Reset (synchronous, active-high):
  - FIFO is emptied.
  - State goes to ST_IDLE.
  - All outputs are 0, except oCP_Ins_Ready = 1 in the first cycle after reset.
  - A reset asserted mid-operation drops all buffered entries.
- NOP encoding is the all-zero word. A NOP is issued with data selection 0 and predication 0.
- Handshake: an entry is pushed when iCP_Ins_Valid & oCP_Ins_Ready at a rising edge.
  - oCP_Ins_Ready = (count < FIFO_DEPTH). It is registered-count based and does not look ahead on a same-cycle pop.
  - Valid may be held across cycles; data must be stable while valid is high and ready is low.
- Output register loads at every edge:
  - FIFO head, popped, when state is ST_ISSUE/ST_IDLE, the FIFO is non-empty, iStall = 0 and iFlush = 0. oIssue_Valid = 1.
  - Otherwise, NOP with oIssue_Valid = 0.
- Latency: an entry pushed into an empty FIFO at edge E0 is popped at E1 and visible on the outputs after E1.
  - The pushed instruction is therefore visible after E1, two edges after the handshake cycle began.
  - Back-to-back pushes then issue one per cycle.
- Simultaneous push and pop: count is unchanged. Ordering is strictly FIFO.
- Full: ready is low; no push occurs even if a pop happens in the same cycle.
- Empty: NOP is issued.
- FIFO read and write pointers wrap modulo FIFO_DEPTH.
- Flush:
  - count, read pointer and write pointer are cleared.
  - Any push in the same cycle is dropped.
  - NOP is issued.
  - Flush has priority over stall and push.
- Stall: no pop; NOP is issued; a push is still accepted when not full.
- State machine (2-bit, registered):
  - ST_IDLE: FIFO empty. Go to ST_ISSUE when count becomes >0; go to ST_HOLD on iStall.
  - ST_ISSUE: issuing. Go to ST_HOLD on iStall. Go to ST_IDLE when the last entry is popped with no push. Go to ST_FLUSH on iFlush.
  - ST_HOLD: emitting NOPs while iStall = 1. When iStall = 0, go to ST_ISSUE if count >0, else ST_IDLE.
  - ST_FLUSH: one cycle, NOP issued, pushes accepted. Then go to ST_IDLE, or ST_ISSUE if a push occurred.
  - iFlush from any state goes to ST_FLUSH.
- oIssue_Count increments on each real issue and wraps at 2^CNT_WIDTH. Only reset clears it; flush does not.

Decomposition:
- Shared package def-pe.v holds:
  - DEF_PE_INS_WIDTH
  - DEF_PE_NOP_INS (all zeros)
  - issue state encodings ST_IDLE = 0, ST_ISSUE = 1, ST_HOLD = 2, ST_FLUSH = 3
- One sub-module, pe_ins_fifo, is natural. It is a synchronous FIFO storing {predication, data selection, instruction}, with push, pop, clear, count, full and empty.
- The FSM, output register and counter stay in the top module.

Test Plan:
- Reset, then push 0x123456 (dsel 2, pred 1) at cycle 3 → outputs show 0x123456/2/1 with oIssue_Valid = 1 in cycle 5 only; NOPs otherwise; oIssue_Count = 1.
- Push 6 instructions back-to-back with no stall → ready drops once count = 4; all 6 are issued in order on consecutive cycles; oIssue_Count = 6.
- Fill FIFO with A,B,C, assert iStall for 3 cycles → 3 NOPs; oFifo_Count holds at 3; after release A,B,C issue on consecutive cycles.
- Count = 3, assert iFlush together with a push of D → next output is NOP; oFifo_Count = 0; D never issues; the next pushed E issues normally.
- Assert iReset with count = 2 mid-stream → all outputs 0 the next cycle; oIssue_Count = 0; buffered entries are never issued.
- Push 2^16 + 2 instructions → oIssue_Count wraps to 2.
